// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - I2S DAC output stage with double-buffered mono sample path
module i2s_transmitter #(
    parameter int IN_WIDTH = 11,
    parameter int DIV_LOG2 = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] sample,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                mclk,
    output logic                sclk,
    output logic                lrck,
    output logic                sdata,
    output logic                underrun
);

    localparam int CW = DIV_LOG2 + 9;

    logic [CW-1:0] cnt;
    logic [23:0]   holding;
    logic [23:0]   frame_reg;
    logic [23:0]   conv;
    logic          holding_full;
    logic          full_next;
    logic          accept;
    logic          latch;
    logic          shift;
    logic [4:0]    p_next;
    logic [4:0]    bit_idx;
    logic          next_bit;

    assign mclk = cnt[DIV_LOG2];
    assign sclk = cnt[DIV_LOG2+2];
    assign lrck = cnt[DIV_LOG2+8];

    // Flipping the MSB turns offset-binary into two's complement; left-justify into 24 bits.
    always_comb begin
        conv = '0;
        conv[23 -: IN_WIDTH] = sample ^ {1'b1, {(IN_WIDTH-1){1'b0}}};
    end

    assign accept = sample_valid && sample_ready;
    assign latch  = &cnt;
    assign shift  = &cnt[DIV_LOG2+2:0];

    // Bit for the slot position that begins on the next SCLK falling edge.
    assign p_next   = cnt[DIV_LOG2+7:DIV_LOG2+3] + 5'd1;
    assign bit_idx  = 5'd24 - p_next;
    assign next_bit = (p_next >= 5'd1 && p_next <= 5'd24) ? frame_reg[bit_idx] : 1'b0;

    always_comb begin
        full_next = holding_full;
        if (latch && holding_full)
            full_next = 1'b0;
        if (accept)
            full_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            holding      <= '0;
            holding_full <= 1'b0;
            frame_reg    <= '0;
            sample_ready <= 1'b0;
            underrun     <= 1'b0;
            sdata        <= 1'b0;
        end else begin
            cnt          <= cnt + 1'b1;
            underrun     <= latch && !holding_full;
            holding_full <= full_next;
            sample_ready <= !full_next;
            if (latch && holding_full)
                frame_reg <= holding;
            if (accept)
                holding <= conv;
            if (shift)
                sdata <= next_bit;
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb/tb_i2s_transmitter.sv - randomized self-checking bench for i2s_transmitter
module tb_i2s_transmitter;

    localparam int IW    = 11;
    localparam int D     = 1;
    localparam int FRAME = 2 ** (D + 9);

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] sample;
    logic          sample_valid;
    logic          sample_ready;
    logic          mclk;
    logic          sclk;
    logic          lrck;
    logic          sdata;
    logic          underrun;

    int          checks = 0;
    int          errors = 0;
    int          n;
    bit          acc;
    logic        m_full;
    logic        e_ready;
    logic        e_und;
    logic [23:0] m_held;
    logic [23:0] m_word;

    i2s_transmitter #(.IN_WIDTH(IW), .DIV_LOG2(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .mclk         (mclk),
        .sclk         (sclk),
        .lrck         (lrck),
        .sdata        (sdata),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [23:0] to_word(input logic [IW-1:0] s);
        int v;
        v = (int'(s) - 2 ** (IW - 1)) * 2 ** (24 - IW);
        return v[23:0];
    endfunction

    // Advance the reference by one clock using current inputs, then compare at the falling edge.
    task automatic tick();
        int          c;
        int          p;
        logic        exp_sd;
        acc = 1'b0;
        if (rst) begin
            n = 0; m_full = 1'b0; m_word = '0; e_ready = 1'b0; e_und = 1'b0;
        end else begin
            e_und = 1'b0;
            if (n % FRAME == FRAME - 1) begin
                if (m_full) begin
                    m_word = m_held;
                    m_full = 1'b0;
                end else begin
                    e_und = 1'b1;
                end
            end
            if (sample_valid && e_ready) begin
                m_held = to_word(sample);
                m_full = 1'b1;
                acc    = 1'b1;
            end
            e_ready = !m_full;
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        c = n % FRAME;
        p = (c >> (D + 3)) % 32;
        exp_sd = (p >= 1 && p <= 24) ? m_word[24 - p] : 1'b0;
        chk("mclk", mclk, (c >> D) & 1);
        chk("sclk", sclk, (c >> (D + 2)) & 1);
        chk("lrck", lrck, (c >> (D + 8)) & 1);
        chk("sdata", sdata, exp_sd);
        chk("underrun", underrun, e_und);
        chk("sample_ready", sample_ready, e_ready);
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) tick();
    endtask

    task automatic send(input logic [IW-1:0] v);
        int k;
        sample = v;
        sample_valid = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!acc && k < 4 * FRAME);
        sample_valid = 1'b0;
    endtask

    task automatic wait_pos(input int target);
        for (int k = 0; k < FRAME && (n % FRAME) != target; k++) tick();
    endtask

    initial begin
        rst = 1'b1; sample_valid = 1'b0; sample = '0;
        n = 0; acc = 1'b0; m_full = 1'b0; e_ready = 1'b0; e_und = 1'b0;
        m_held = '0; m_word = '0;
        @(negedge clk);
        idle(3);
        rst = 1'b0;

        idle(3 * FRAME);

        send(11'h7FF);
        send(11'h000);
        send(11'h400);
        idle(2 * FRAME);

        sample = IW'($urandom);
        sample_valid = 1'b1;
        for (int k = 0; k < 6 * FRAME; k++) begin
            tick();
            if (acc) sample = IW'($urandom);
        end
        sample_valid = 1'b0;
        idle(2 * FRAME);

        wait_pos(FRAME - 1);
        send(IW'($urandom));
        idle(2 * FRAME);

        for (int k = 0; k < 6 * FRAME; k++) begin
            if (!sample_valid && $urandom_range(0, 299) == 0) begin
                sample_valid = 1'b1;
                sample = IW'($urandom);
            end
            tick();
            if (acc) sample_valid = 1'b0;
        end
        sample_valid = 1'b0;
        idle(2 * FRAME);

        wait_pos(50);
        send(11'h123);
        wait_pos(700);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2 * FRAME + 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Serial audio output stage for the sound path: takes unsigned mixed samples from the mixer through a valid/ready handshake and drives an I2S DAC (Pmod I2S2 style).
- Generates MCLK, SCLK and LRCK from the system clock.
- Converts each sample to 24-bit two's complement and transmits it MSB-first on both left and right channels (mono).
- Double-buffered, so the upstream producer has a full frame period to supply the next sample.
- On underrun, repeats the last sample and flags the event.

## Interface

Parameters:
- IN_WIDTH, default 11, width of the unsigned input sample (the 8-channel, 8-bit mixer output with no shift); legal range 2..24.
- DIV_LOG2, default 1: clock division exponent. D below means DIV_LOG2.
  - MCLK = clk / 2^(D+1), SCLK = clk / 2^(D+3), LRCK = clk / 2^(D+9).
  - At 100 MHz with the default: 25 MHz, 6.25 MHz and 97.66 kHz.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sample  in  IN_WIDTH  unsigned sample; mid-scale 2^(IN_WIDTH-1) is silence.
- sample_valid  in  1  producer has a sample.
- sample_ready  out  1  registered; holding buffer empty.
- mclk  out  1  DAC master clock.
- sclk  out  1  serial bit clock.
- lrck  out  1  word select: 0 = left, 1 = right.
- sdata  out  1  serial data.
- underrun  out  1  one-cycle pulse: a frame started with no new sample.

## Operation

- Free-running counter cnt, D+9 bits, increments every cycle and wraps to 0.
  - mclk = cnt[D], sclk = cnt[D+2], lrck = cnt[D+8]; these are register bits, glitch-free.
- Slot position p = cnt[D+7:D+3] (0..31); 32 SCLK periods per channel, 64 per frame.
- Sample conversion: word[23:0] = {~sample[IN_WIDTH-1], sample[IN_WIDTH-2:0], (24-IN_WIDTH) zeros}.
- Handshake:
  - Accept when sample_valid && sample_ready.
  - An accepted sample goes into the holding register; holding becomes full and sample_ready drops the next cycle.
- Frame latch, in the cycle cnt == all ones (the end of the right slot):
  - If holding is full: frame_reg <= holding, holding becomes empty, sample_ready = 1 the next cycle.
  - If holding is empty: frame_reg keeps its value and underrun pulses high for exactly the next cycle.
  - The full/empty decision uses holding state before any same-cycle accept.
  - Latch with holding empty and an accept in the same cycle: the sample fills holding for the following frame, and underrun still pulses.
- Data shift, in each cycle with cnt[D+2:0] all ones (an SCLK falling edge occurs next cycle): sdata is loaded with the bit for the upcoming position p.
  - p = 0 gives 0.
  - p = 1..24 gives word[24-p], from frame_reg; the MSB is one SCLK after the LRCK edge (standard I2S).
  - p = 25..31 gives 0.
  - The left and right slots carry the identical word.
- sdata changes coincident with SCLK falling; the DAC samples on SCLK rising.

## Timing

- Reset values:
  - cnt = 0, so mclk, sclk and lrck are 0.
  - sdata = 0, underrun = 0, sample_ready = 0.
  - holding empty; frame_reg = mid-scale (word 0).
- sample_ready is 1 in the first cycle after rst deasserts.
- Reset asserted mid-frame aborts the frame and discards a pending held sample; outputs take reset values the next cycle.
- Latency: a sample accepted before the latch cycle has its MSB on sdata at cnt = 2^(D+3) of the next frame.
  - With D = 1 that is 16 cycles after the wrap, i.e. 17 cycles after the latch cycle.
- Sustained throughput: one sample per 2^(D+9) cycles.
- sample_ready is never high while holding is full.
- A second sample cannot be accepted until the next latch.

## Test plan

- Reset, then idle with sample_valid = 0, D = 1:
  - mclk toggles every 2 cycles, sclk every 8, lrck every 512.
  - sdata stays 0; underrun pulses at each frame wrap; sample_ready = 1.
- Send sample 0x7FF, 11-bit:
  - The decoded 24-bit word on both slots is 0x7FE000.
  - MSB (0) appears 17 cycles after the latch cycle; positions 25..31 are 0; no underrun that frame.
- Send 0x000, then 0x400 on successive frames:
  - Words decode as 0x800000, then 0x000000.
- Keep sample_valid high continuously:
  - Exactly one accept per frame; sample_ready low between latches.
  - No underrun; samples appear in order with no repeats.
- Assert valid first in the latch cycle with holding empty:
  - underrun pulses; the previous word repeats.
  - The new sample appears in the following frame.
- Assert rst mid-right-slot with holding full:
  - All outputs return to reset values; the held sample is never transmitted.
  - The next frame carries word 0.
